// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C target: protocol state encoding and the R/W bit value.
package i2c_pkg;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_ADDR      = 4'd1,
    ST_ADDR_ACK  = 4'd2,
    ST_PTR       = 4'd3,
    ST_PTR_ACK   = 4'd4,
    ST_WDATA     = 4'd5,
    ST_WDATA_ACK = 4'd6,
    ST_RDATA     = 4'd7,
    ST_RDATA_ACK = 4'd8,
    ST_WAIT_STOP = 4'd9
  } state_t;

  localparam logic I2C_RW_READ = 1'b1;

endpackage

// File: rtl/i2c_line_filter.sv
// Conditions one open-drain bus line: 2-flop synchronizer, FILT_LEN-cycle glitch
// filter, and single-cycle rise/fall pulses aligned with the filtered level change.
module i2c_line_filter #(
  parameter int FILT_LEN = 3
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_line,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  localparam int CW = $clog2(FILT_LEN + 1);

  logic [1:0]    r_sync;
  logic          r_level;
  logic [CW-1:0] r_cnt;
  logic          r_rise;
  logic          r_fall;

  // Idle bus lines float high, so every stage resets to 1 to avoid a phantom edge.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sync  <= 2'b11;
      r_level <= 1'b1;
      r_cnt   <= '0;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
    end else begin
      // NOTE: every flop here uses <= so all stages see the pre-edge values of their neighbours.
      r_sync <= {r_sync[0], i_line};
      r_rise <= 1'b0;
      r_fall <= 1'b0;
      if (r_sync[1] == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == CW'(FILT_LEN - 1)) begin
        r_level <= r_sync[1];
        r_cnt   <= '0;
        r_rise  <= r_sync[1];
        r_fall  <= ~r_sync[1];
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  assign o_level = r_level;
  assign o_rise  = r_rise;
  assign o_fall  = r_fall;

endmodule

// File: rtl/i2c_target.sv
// I2C target exposing NREGS byte registers: pointer byte then data on write,
// auto-incrementing reads; never stretches SCL and drives SDA open-drain only.
module i2c_target
  import i2c_pkg::*;
#(
  parameter logic [6:0] ADDR     = 7'h42,
  parameter int         NREGS    = 4,
  parameter int         FILT_LEN = 3,
  localparam int        PW       = $clog2(NREGS)
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          SCL,
  input  logic          SDA_IN,
  output logic          SDA_OE,
  input  logic [PW-1:0] HOST_ADDR,
  output logic [7:0]    HOST_RDATA,
  output logic          WR_STB,
  output logic [PW-1:0] WR_IDX,
  output logic [7:0]    WR_DATA,
  output logic          BUSY
);

  logic w_scl, w_scl_rise, w_scl_fall;
  logic w_sda, w_sda_rise, w_sda_fall;

  i2c_line_filter #(.FILT_LEN(FILT_LEN)) u_scl_filt (
    .i_clk  (CLK),
    .i_rst  (RST),
    .i_line (SCL),
    .o_level(w_scl),
    .o_rise (w_scl_rise),
    .o_fall (w_scl_fall)
  );

  i2c_line_filter #(.FILT_LEN(FILT_LEN)) u_sda_filt (
    .i_clk  (CLK),
    .i_rst  (RST),
    .i_line (SDA_IN),
    .o_level(w_sda),
    .o_rise (w_sda_rise),
    .o_fall (w_sda_fall)
  );

  state_t        r_state;
  logic [7:0]    r_shift;
  logic [2:0]    r_bitcnt;
  logic [PW-1:0] r_ptr;
  logic [7:0]    r_regs [NREGS];
  logic          r_sda_oe;
  logic          r_busy;
  logic          r_rw;
  logic          r_wr_stb;
  logic [PW-1:0] r_wr_idx;
  logic [7:0]    r_wr_data;

  logic          w_start;
  logic          w_stop;
  logic [7:0]    w_byte;
  logic          w_last;
  logic [PW-1:0] w_ptr_next;

  assign w_start    = w_sda_fall & w_scl;
  assign w_stop     = w_sda_rise & w_scl;
  assign w_byte     = {r_shift[6:0], w_sda};
  assign w_last     = (r_bitcnt == 3'd7);
  assign w_ptr_next = r_ptr + PW'(1);

  // ACK states: the fall ending bit 8 pulls SDA, the rise of bit 9 moves on, and the
  // following state's first SCL fall releases (or drives the next read bit).
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state   <= ST_IDLE;
      r_shift   <= '0;
      r_bitcnt  <= '0;
      r_ptr     <= '0;
      r_sda_oe  <= 1'b0;
      r_busy    <= 1'b0;
      r_rw      <= 1'b0;
      r_wr_stb  <= 1'b0;
      r_wr_idx  <= '0;
      r_wr_data <= '0;
      // NOTE: the bank is small and architecturally reset to zero, so it is built from flops, not RAM.
      for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
    end else begin
      r_wr_stb <= 1'b0;
      if (w_stop) begin
        r_state  <= ST_IDLE;
        r_sda_oe <= 1'b0;
        r_busy   <= 1'b0;
      end else if (w_start) begin
        r_state  <= ST_ADDR;
        r_bitcnt <= '0;
        r_sda_oe <= 1'b0;
        r_busy   <= 1'b0;
      end else begin
        case (r_state)
          ST_ADDR: begin
            if (w_scl_rise) begin
              r_shift  <= w_byte;
              r_bitcnt <= r_bitcnt + 3'd1;
              if (w_last) begin
                if (w_byte[7:1] == ADDR) begin
                  r_state <= ST_ADDR_ACK;
                  r_busy  <= 1'b1;
                  r_rw    <= w_byte[0];
                end else begin
                  r_state <= ST_WAIT_STOP;
                end
              end
            end
          end
          ST_ADDR_ACK: begin
            if (w_scl_fall) begin
              r_sda_oe <= 1'b1;
            end else if (w_scl_rise) begin
              r_bitcnt <= '0;
              if (r_rw == I2C_RW_READ) begin
                r_shift <= r_regs[r_ptr];
                r_state <= ST_RDATA;
              end else begin
                r_state <= ST_PTR;
              end
            end
          end
          ST_PTR: begin
            if (w_scl_fall) r_sda_oe <= 1'b0;
            if (w_scl_rise) begin
              r_shift  <= w_byte;
              r_bitcnt <= r_bitcnt + 3'd1;
              if (w_last) begin
                r_ptr   <= w_byte[PW-1:0];
                r_state <= ST_PTR_ACK;
              end
            end
          end
          ST_PTR_ACK, ST_WDATA_ACK: begin
            if (w_scl_fall) begin
              r_sda_oe <= 1'b1;
            end else if (w_scl_rise) begin
              r_bitcnt <= '0;
              r_state  <= ST_WDATA;
            end
          end
          ST_WDATA: begin
            if (w_scl_fall) r_sda_oe <= 1'b0;
            if (w_scl_rise) begin
              r_shift  <= w_byte;
              r_bitcnt <= r_bitcnt + 3'd1;
              if (w_last) begin
                r_regs[r_ptr] <= w_byte;
                r_wr_stb      <= 1'b1;
                r_wr_idx      <= r_ptr;
                r_wr_data     <= w_byte;
                r_ptr         <= w_ptr_next;
                r_state       <= ST_WDATA_ACK;
              end
            end
          end
          ST_RDATA: begin
            if (w_scl_fall) begin
              r_sda_oe <= ~r_shift[7];
              r_shift  <= {r_shift[6:0], 1'b0};
            end else if (w_scl_rise) begin
              r_bitcnt <= r_bitcnt + 3'd1;
              if (w_last) r_state <= ST_RDATA_ACK;
            end
          end
          ST_RDATA_ACK: begin
            if (w_scl_fall) begin
              r_sda_oe <= 1'b0;
            end else if (w_scl_rise) begin
              r_ptr <= w_ptr_next;
              if (!w_sda) begin
                r_shift  <= r_regs[w_ptr_next];
                r_bitcnt <= '0;
                r_state  <= ST_RDATA;
              end else begin
                r_state <= ST_WAIT_STOP;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Gating with RST lets the pin release in the same delta the reset arrives.
  assign SDA_OE     = r_sda_oe & ~RST;
  assign HOST_RDATA = r_regs[HOST_ADDR];
  assign WR_STB     = r_wr_stb;
  assign WR_IDX     = r_wr_idx;
  assign WR_DATA    = r_wr_data;
  assign BUSY       = r_busy;

endmodule

// File: tb/tb_i2c_target.sv
// Bench for i2c_target: a bit-level bus controller plus a register/pointer model
// that predicts write events, read bytes and bank contents from transaction rules.
module tb_i2c_target;
  import i2c_pkg::*;

  localparam int NREGS = 4;
  localparam int PW    = 2;
  localparam int Q     = 10;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          SCL = 1'b1;
  logic          sda_c = 1'b1;
  logic          glitch = 1'b0;
  logic          SDA_IN, SDA_OE, WR_STB, BUSY;
  logic [PW-1:0] HOST_ADDR = '0;
  logic [PW-1:0] WR_IDX;
  logic [7:0]    HOST_RDATA, WR_DATA;

  assign SDA_IN = sda_c & ~SDA_OE & ~glitch;

  i2c_target #(.ADDR(7'h42), .NREGS(NREGS), .FILT_LEN(3)) dut (
    .CLK(CLK), .RST(RST), .SCL(SCL), .SDA_IN(SDA_IN), .SDA_OE(SDA_OE),
    .HOST_ADDR(HOST_ADDR), .HOST_RDATA(HOST_RDATA), .WR_STB(WR_STB),
    .WR_IDX(WR_IDX), .WR_DATA(WR_DATA), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  int            n_cmp = 0;
  int            n_err = 0;
  logic [7:0]    mdl_regs [NREGS];
  int            mdl_ptr;
  logic [PW+7:0] exp_q [$];
  logic [PW+7:0] got_q [$];
  int            oe_cnt;

  always @(negedge CLK) begin
    if (WR_STB) got_q.push_back({WR_IDX, WR_DATA});
    if (SDA_OE) oe_cnt++;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish within 1 ms");
    $fatal(1);
  end

  // ---------------- bus controller ----------------
  task automatic wait_q();
    repeat (Q) @(negedge CLK);
  endtask

  task automatic bus_start();
    sda_c = 1'b1; wait_q();
    SCL = 1'b1;   wait_q();
    sda_c = 1'b0; wait_q();
    SCL = 1'b0;   wait_q();
  endtask

  task automatic bus_stop();
    sda_c = 1'b0; wait_q();
    SCL = 1'b1;   wait_q();
    sda_c = 1'b1; wait_q();
  endtask

  task automatic send_bit(input logic b);
    sda_c = b; wait_q();
    SCL = 1'b1; wait_q(); wait_q();
    SCL = 1'b0; wait_q();
  endtask

  task automatic recv_bit(output logic b);
    sda_c = 1'b1; wait_q();
    SCL = 1'b1; wait_q();
    b = SDA_IN; wait_q();
    SCL = 1'b0; wait_q();
  endtask

  task automatic send_byte(input logic [7:0] d, output logic ack_n);
    for (int i = 7; i >= 0; i--) send_bit(d[i]);
    recv_bit(ack_n);
  endtask

  task automatic recv_byte(output logic [7:0] d, input logic nack);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      recv_bit(b);
      d[i] = b;
    end
    send_bit(nack);
  endtask

  // ackmask bit k is the ACK-slot level of byte k (address byte is k=0); 1 means NACK.
  task automatic xfer_write(input logic [7:0] addr_byte, input logic [7:0] bytes[$],
                            input logic do_stop, output logic [7:0] ackmask);
    logic a;
    ackmask = '0;
    bus_start();
    send_byte(addr_byte, a);
    ackmask[0] = a;
    foreach (bytes[i]) begin
      send_byte(bytes[i], a);
      ackmask[i+1] = a;
    end
    if (do_stop) bus_stop();
  endtask

  task automatic xfer_read(input int n, output logic [7:0] got[$], output logic addr_ack_n);
    logic [7:0] d;
    got.delete();
    bus_start();
    send_byte(8'h85, addr_ack_n);
    for (int i = 0; i < n; i++) begin
      recv_byte(d, (i == n - 1));
      got.push_back(d);
    end
  endtask

  // ---------------- reference model ----------------
  task automatic mdl_reset();
    for (int i = 0; i < NREGS; i++) mdl_regs[i] = 8'h00;
    mdl_ptr = 0;
  endtask

  task automatic mdl_write(input logic [7:0] bytes[$]);
    mdl_ptr = int'(bytes[0]) % NREGS;
    for (int i = 1; i < bytes.size(); i++) begin
      exp_q.push_back({PW'(mdl_ptr), bytes[i]});
      mdl_regs[mdl_ptr] = bytes[i];
      mdl_ptr = (mdl_ptr + 1) % NREGS;
    end
  endtask

  function automatic logic [7:0] mdl_read();
    logic [7:0] v;
    v = mdl_regs[mdl_ptr];
    mdl_ptr = (mdl_ptr + 1) % NREGS;
    return v;
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    RST = 1'b1; SCL = 1'b1; sda_c = 1'b1;
    repeat (5) @(negedge CLK);
    RST = 1'b0;
    repeat (2) @(negedge CLK);
    mdl_reset();
    n_cmp++; if (SDA_OE !== 1'b0) begin n_err++; $display("FAIL reset_sda_oe got %b exp 0", SDA_OE); end
    n_cmp++; if (BUSY !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b exp 0", BUSY); end
    n_cmp++;
    if ({WR_STB, WR_IDX, WR_DATA} !== '0) begin
      n_err++; $display("FAIL reset_wr got stb=%b idx=%0d data=%h exp all 0", WR_STB, WR_IDX, WR_DATA);
    end
    for (int i = 0; i < NREGS; i++) begin
      HOST_ADDR = PW'(i); #1;
      n_cmp++;
      if (HOST_RDATA !== 8'h00) begin n_err++; $display("FAIL reset_reg%0d got %h exp 00", i, HOST_RDATA); end
    end
  endtask

  task automatic test_write();
    logic [7:0] bq[$];
    logic [7:0] am;
    got_q.delete(); exp_q.delete();
    bq = {8'h01, 8'hA5, 8'h3C};
    xfer_write(8'h84, bq, 1'b0, am);
    n_cmp++; if (BUSY !== 1'b1) begin n_err++; $display("FAIL write_busy_active got %b exp 1", BUSY); end
    bus_stop();
    mdl_write(bq);
    n_cmp++; if (am[3:0] !== 4'b0000) begin n_err++; $display("FAIL write_acks got %b exp 0000", am[3:0]); end
    n_cmp++; if (BUSY !== 1'b0) begin n_err++; $display("FAIL write_busy_after_stop got %b exp 0", BUSY); end
    n_cmp++;
    if (got_q.size() !== exp_q.size()) begin
      n_err++; $display("FAIL write_stb_count got %0d exp %0d", got_q.size(), exp_q.size());
    end else begin
      foreach (exp_q[i]) begin
        n_cmp++;
        if (got_q[i] !== exp_q[i]) begin n_err++; $display("FAIL write_stb%0d got %h exp %h", i, got_q[i], exp_q[i]); end
      end
    end
    for (int i = 0; i < NREGS; i++) begin
      HOST_ADDR = PW'(i); #1;
      n_cmp++;
      if (HOST_RDATA !== mdl_regs[i]) begin n_err++; $display("FAIL write_reg%0d got %h exp %h", i, HOST_RDATA, mdl_regs[i]); end
    end
  endtask

  task automatic test_ptr_wrap();
    logic [7:0] bq[$];
    logic [7:0] am;
    got_q.delete(); exp_q.delete();
    bq = {8'h03, 8'h11, 8'h22};
    xfer_write(8'h84, bq, 1'b1, am);
    mdl_write(bq);
    n_cmp++; if (am[3:0] !== 4'b0000) begin n_err++; $display("FAIL wrap_acks got %b exp 0000", am[3:0]); end
    n_cmp++;
    if (got_q.size() !== exp_q.size()) begin
      n_err++; $display("FAIL wrap_stb_count got %0d exp %0d", got_q.size(), exp_q.size());
    end else begin
      foreach (exp_q[i]) begin
        n_cmp++;
        if (got_q[i] !== exp_q[i]) begin n_err++; $display("FAIL wrap_stb%0d got %h exp %h", i, got_q[i], exp_q[i]); end
      end
    end
    for (int i = 0; i < NREGS; i++) begin
      HOST_ADDR = PW'(i); #1;
      n_cmp++;
      if (HOST_RDATA !== mdl_regs[i]) begin n_err++; $display("FAIL wrap_reg%0d got %h exp %h", i, HOST_RDATA, mdl_regs[i]); end
    end
  endtask

  task automatic test_combined_read();
    logic [7:0] bq[$];
    logic [7:0] rd[$];
    logic [7:0] am, e;
    logic       a;
    bq = {8'h01};
    xfer_write(8'h84, bq, 1'b0, am);
    mdl_write(bq);
    xfer_read(2, rd, a);
    n_cmp++; if (a !== 1'b0) begin n_err++; $display("FAIL cread_addr_ack got %b exp 0", a); end
    foreach (rd[i]) begin
      e = mdl_read();
      n_cmp++;
      if (rd[i] !== e) begin n_err++; $display("FAIL cread_byte%0d got %h exp %h", i, rd[i], e); end
    end
    repeat (2) @(negedge CLK);
    n_cmp++; if (SDA_OE !== 1'b0) begin n_err++; $display("FAIL cread_release_after_nack got %b exp 0", SDA_OE); end
    bus_stop();
    xfer_read(1, rd, a);
    bus_stop();
    e = mdl_read();
    n_cmp++;
    if (rd[0] !== e) begin n_err++; $display("FAIL cread_resume got %h exp %h", rd[0], e); end
  endtask

  task automatic test_wrong_addr();
    logic [7:0] bq[$];
    logic [7:0] am;
    got_q.delete();
    oe_cnt = 0;
    bq = {8'h55};
    xfer_write(8'h86, bq, 1'b1, am);
    n_cmp++; if (am[0] !== 1'b1) begin n_err++; $display("FAIL wrong_addr_ack got %b exp 1", am[0]); end
    n_cmp++; if (oe_cnt !== 0) begin n_err++; $display("FAIL wrong_addr_sda_oe got %0d cycles exp 0", oe_cnt); end
    n_cmp++; if (got_q.size() !== 0) begin n_err++; $display("FAIL wrong_addr_stb got %0d exp 0", got_q.size()); end
    n_cmp++; if (BUSY !== 1'b0) begin n_err++; $display("FAIL wrong_addr_busy got %b exp 0", BUSY); end
  endtask

  task automatic test_abort();
    logic [7:0] bq[$];
    logic [7:0] am;
    got_q.delete();
    bq = {8'h00};
    xfer_write(8'h84, bq, 1'b0, am);
    mdl_write(bq);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
    bus_start();
    bus_stop();
    n_cmp++; if (got_q.size() !== 0) begin n_err++; $display("FAIL abort_stb got %0d exp 0", got_q.size()); end
    for (int i = 0; i < NREGS; i++) begin
      HOST_ADDR = PW'(i); #1;
      n_cmp++;
      if (HOST_RDATA !== mdl_regs[i]) begin n_err++; $display("FAIL abort_reg%0d got %h exp %h", i, HOST_RDATA, mdl_regs[i]); end
    end
  endtask

  task automatic test_glitch();
    logic a;
    SCL = 1'b1; sda_c = 1'b1;
    wait_q();
    @(negedge CLK) glitch = 1'b1;
    @(negedge CLK) glitch = 1'b0;
    wait_q();
    n_cmp++; if (dut.r_state !== ST_IDLE) begin n_err++; $display("FAIL glitch_state got %0d exp %0d", dut.r_state, ST_IDLE); end
    SCL = 1'b0; wait_q();
    send_byte(8'h84, a);
    n_cmp++; if (a !== 1'b1) begin n_err++; $display("FAIL glitch_no_ack got %b exp 1", a); end
    n_cmp++; if (BUSY !== 1'b0) begin n_err++; $display("FAIL glitch_busy got %b exp 0", BUSY); end
    bus_stop();
  endtask

  task automatic test_random();
    logic [7:0] bq[$];
    logic [7:0] rd[$];
    logic [7:0] am, e;
    logic       a;
    int         n;
    for (int it = 0; it < 6; it++) begin
      got_q.delete(); exp_q.delete();
      n = $urandom_range(1, 3);
      bq.delete();
      bq.push_back(8'($urandom));
      for (int k = 0; k < n; k++) bq.push_back(8'($urandom));
      xfer_write(8'h84, bq, 1'b1, am);
      mdl_write(bq);
      n_cmp++; if (am !== 8'h00) begin n_err++; $display("FAIL rand%0d_acks got %b exp 0", it, am); end
      n_cmp++;
      if (got_q.size() !== exp_q.size()) begin
        n_err++; $display("FAIL rand%0d_stb_count got %0d exp %0d", it, got_q.size(), exp_q.size());
      end else begin
        foreach (exp_q[i]) begin
          n_cmp++;
          if (got_q[i] !== exp_q[i]) begin n_err++; $display("FAIL rand%0d_stb%0d got %h exp %h", it, i, got_q[i], exp_q[i]); end
        end
      end
      bq = {8'($urandom)};
      xfer_write(8'h84, bq, 1'b0, am);
      mdl_write(bq);
      xfer_read($urandom_range(1, 4), rd, a);
      bus_stop();
      foreach (rd[i]) begin
        e = mdl_read();
        n_cmp++;
        if (rd[i] !== e) begin n_err++; $display("FAIL rand%0d_read%0d got %h exp %h", it, i, rd[i], e); end
      end
    end
    for (int i = 0; i < NREGS; i++) begin
      HOST_ADDR = PW'(i); #1;
      n_cmp++;
      if (HOST_RDATA !== mdl_regs[i]) begin n_err++; $display("FAIL rand_reg%0d got %h exp %h", i, HOST_RDATA, mdl_regs[i]); end
    end
  endtask

  task automatic test_reset_mid_read();
    logic [7:0] bq[$];
    logic [7:0] am;
    logic       a, b;
    bq = {8'h02, 8'h00};
    xfer_write(8'h84, bq, 1'b1, am);
    mdl_write(bq);
    bq = {8'h02};
    xfer_write(8'h84, bq, 1'b0, am);
    mdl_write(bq);
    bus_start();
    send_byte(8'h85, a);
    recv_bit(b); recv_bit(b); recv_bit(b);
    sda_c = 1'b1; wait_q();
    SCL = 1'b1;   wait_q();
    n_cmp++; if (SDA_OE !== 1'b1) begin n_err++; $display("FAIL rstmid_driving got %b exp 1", SDA_OE); end
    #2 RST = 1'b1;
    #1;
    n_cmp++; if (SDA_OE !== 1'b0) begin n_err++; $display("FAIL rstmid_sda_oe got %b exp 0", SDA_OE); end
    repeat (3) @(negedge CLK);
    RST = 1'b0;
    mdl_reset();
    repeat (10) @(negedge CLK);
    n_cmp++; if (dut.r_state !== ST_IDLE) begin n_err++; $display("FAIL rstmid_state got %0d exp %0d", dut.r_state, ST_IDLE); end
    n_cmp++; if (BUSY !== 1'b0) begin n_err++; $display("FAIL rstmid_busy got %b exp 0", BUSY); end
    for (int i = 0; i < NREGS; i++) begin
      HOST_ADDR = PW'(i); #1;
      n_cmp++;
      if (HOST_RDATA !== mdl_regs[i]) begin n_err++; $display("FAIL rstmid_reg%0d got %h exp %h", i, HOST_RDATA, mdl_regs[i]); end
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_ptr_wrap();
    test_combined_read();
    test_wrong_addr();
    test_abort();
    test_glitch();
    test_random();
    test_reset_mid_read();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
